// File: rtl/regfile_pkg.sv
// Shared definitions for the stack-machine register file: address map,
// address decode helper and the port arbiter state encoding.
package regfile_pkg;

   localparam logic [3:0] RA_ADDR = 4'd0;
   localparam logic [3:0] IN_ADDR = 4'd1;
   localparam logic [3:0] DR_ADDR = 4'd2;
   localparam logic [3:0] SP_ADDR = 4'd3;
   localparam logic [3:0] ST_ADDR = 4'd5;
   localparam logic [3:0] CS_ADDR = 4'd6;
   localparam logic [3:0] EC_ADDR = 4'd7;
   localparam logic [3:0] CF_ADDR = 4'd8;
   localparam logic [3:0] CV_ADDR = 4'd9;
   localparam logic [3:0] OP_ADDR = 4'd10;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_RWAIT = 2'd2;
   localparam logic [1:0] ST_ERR   = 2'd3;

   function automatic logic addr_mapped(input logic [3:0] addr);
      logic hit;
      case (addr)
         RA_ADDR, IN_ADDR, DR_ADDR, SP_ADDR, ST_ADDR,
         CS_ADDR, EC_ADDR, CF_ADDR, CV_ADDR, OP_ADDR: hit = 1'b1;
         default:                                     hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request bit at or above ptr, wrapping at NREQ.
module rr_pick #(
   parameter int NREQ = 3,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx,
   output logic            any
);

   logic [IW:0]   sum;
   logic [IW-1:0] pos;

   // Scan from the farthest offset down so the nearest set bit wins last.
   always_comb begin
      idx = '0;
      any = 1'b0;
      sum = '0;
      pos = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         sum = {1'b0, ptr} + (IW+1)'(k);
         if (sum >= (IW+1)'(NREQ)) begin
            sum = sum - (IW+1)'(NREQ);
         end
         pos = sum[IW-1:0];
         if (req[pos]) begin
            idx = pos;
            any = 1'b1;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
         assign grant[gi] = any && (idx == IW'(gi));
      end
   endgenerate

endmodule

// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter sharing the register file's single port among NREQ
// requesters; waits out the registered read and flags unmapped addresses.
module regfile_port_arbiter
   import regfile_pkg::*;
#(
   parameter int NREQ = 3,
   parameter int AW   = 4,
   parameter int DW   = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   req_we,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   rvalid,
   output logic [DW-1:0]     rdata,
   output logic [NREQ-1:0]   err,
   output logic [AW-1:0]     rf_addr,
   output logic [DW-1:0]     rf_din,
   output logic              rf_we,
   input  logic [DW-1:0]     rf_dout
);

   localparam int IW = $clog2(NREQ);

   logic [1:0]      state_reg;
   logic [IW-1:0]   ptr_reg;
   logic [IW-1:0]   cap_idx_reg;
   logic            cap_we_reg;
   logic [NREQ-1:0] gnt_reg;
   logic [NREQ-1:0] rvalid_reg;
   logic [NREQ-1:0] err_reg;
   logic [AW-1:0]   rf_addr_reg;
   logic [DW-1:0]   rf_din_reg;
   logic            rf_we_reg;

   logic [NREQ-1:0] win_onehot;
   logic [IW-1:0]   win_idx;
   logic            win_any;
   logic [AW-1:0]   win_addr;
   logic            win_mapped;
   logic [NREQ-1:0] cap_onehot;
   logic [IW-1:0]   ptr_next;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .req   (req),
      .ptr   (ptr_reg),
      .grant (win_onehot),
      .idx   (win_idx),
      .any   (win_any)
   );

   assign win_addr   = req_addr[win_idx*AW +: AW];
   // Address bits above the 4-bit map are never mapped.
   assign win_mapped = addr_mapped(win_addr[3:0]) && ((win_addr >> 4) == '0);
   assign ptr_next   = (cap_idx_reg == IW'(NREQ - 1)) ? '0 : cap_idx_reg + 1'b1;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_cap_onehot
         assign cap_onehot[gi] = (cap_idx_reg == IW'(gi));
      end
   endgenerate

   // Strobes are registered on the edge that enters the state they belong to.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= ST_IDLE;
         ptr_reg     <= '0;
         cap_idx_reg <= '0;
         cap_we_reg  <= 1'b0;
         gnt_reg     <= '0;
         rvalid_reg  <= '0;
         err_reg     <= '0;
         rf_addr_reg <= '0;
         rf_din_reg  <= '0;
         rf_we_reg   <= 1'b0;
      end else begin
         gnt_reg    <= '0;
         rvalid_reg <= '0;
         err_reg    <= '0;
         rf_we_reg  <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (win_any) begin
                  cap_idx_reg <= win_idx;
                  cap_we_reg  <= req_we[win_idx];
                  if (win_mapped) begin
                     state_reg   <= ST_ISSUE;
                     gnt_reg     <= win_onehot;
                     rf_addr_reg <= win_addr;
                     rf_din_reg  <= req_wdata[win_idx*DW +: DW];
                     rf_we_reg   <= req_we[win_idx];
                  end else begin
                     state_reg <= ST_ERR;
                     err_reg   <= win_onehot;
                  end
               end
            end
            ST_ISSUE: begin
               ptr_reg <= ptr_next;
               if (cap_we_reg) begin
                  state_reg <= ST_IDLE;
               end else begin
                  state_reg  <= ST_RWAIT;
                  rvalid_reg <= cap_onehot;
               end
            end
            ST_RWAIT: begin
               state_reg <= ST_IDLE;
            end
            default: begin
               ptr_reg   <= ptr_next;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign gnt     = gnt_reg;
   assign rvalid  = rvalid_reg;
   assign err     = err_reg;
   assign rf_addr = rf_addr_reg;
   assign rf_din  = rf_din_reg;
   assign rf_we   = rf_we_reg;
   assign rdata   = (state_reg == ST_ERR) ? '0 : rf_dout;

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural registered-read
// register file attached to the rf_* port.
module tb_regfile_port_arbiter;

   localparam int NREQ = 3;
   localparam int AW   = 4;
   localparam int DW   = 16;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic [NREQ-1:0]    req = '0;
   logic [NREQ-1:0]    req_we = '0;
   logic [NREQ*AW-1:0] req_addr = '0;
   logic [NREQ*DW-1:0] req_wdata = '0;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    rvalid;
   logic [DW-1:0]      rdata;
   logic [NREQ-1:0]    err;
   logic [AW-1:0]      rf_addr;
   logic [DW-1:0]      rf_din;
   logic               rf_we;
   logic [DW-1:0]      rf_dout = '0;

   logic [DW-1:0]      mem [16];

   int checks = 0;
   int failures = 0;

   regfile_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .req       (req),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .err       (err),
      .rf_addr   (rf_addr),
      .rf_din    (rf_din),
      .rf_we     (rf_we),
      .rf_dout   (rf_dout)
   );

   always #5 clk = ~clk;

   // Register file model: write on rf_we, registered read of rf_addr.
   always @(posedge clk) begin
      if (rf_we) mem[rf_addr] <= rf_din;
      rf_dout <= mem[rf_addr];
   end

   always @(negedge clk) begin
      if (reset && ((gnt | rvalid | err) != '0))
         $display("txn t=%0t gnt=%b rvalid=%b err=%b rf_addr=%0d rf_we=%b rdata=%h",
                  $time, gnt, rvalid, err, rf_addr, rf_we, rdata);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
      req_we[i]              = we;
      req_addr[i*AW +: AW]   = a;
      req_wdata[i*DW +: DW]  = d;
   endtask

   int rv_count;
   int others;
   logic found;

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 16'h1000 + 16'(i);

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_gnt", 32'(gnt), 0);
      check("rst_rf_we", 32'(rf_we), 0);
      check("rst_rf_addr", 32'(rf_addr), 0);
      check("rst_rf_din", 32'(rf_din), 0);
      reset = 1'b1;
      step();

      // 1: reset during RWAIT aborts the read
      set_req(0, 1'b0, 4'd3, 16'h0);
      req = 3'b001;
      step();
      check("t1_gnt", 32'(gnt), 32'b001);
      req = 3'b000;
      step();
      check("t1_rvalid_pre", 32'(rvalid), 32'b001);
      reset = 1'b0;
      #1;
      check("t1_rst_rvalid", 32'(rvalid), 0);
      check("t1_rst_gnt", 32'(gnt), 0);
      check("t1_rst_err", 32'(err), 0);
      check("t1_rst_rf_addr", 32'(rf_addr), 0);
      check("t1_rst_state", 32'(dut.state_reg), 0);
      @(negedge clk);
      reset = 1'b1;
      rv_count = 0;
      for (int c = 0; c < 4; c++) begin
         step();
         if (rvalid != '0) rv_count++;
      end
      check("t1_no_rvalid", 32'(rv_count), 0);

      // 2: single write then read back
      set_req(0, 1'b1, 4'd3, 16'hBEEF);
      req = 3'b001;
      step();
      check("t2_w_gnt", 32'(gnt), 32'b001);
      check("t2_w_rf_we", 32'(rf_we), 1);
      check("t2_w_rf_addr", 32'(rf_addr), 3);
      check("t2_w_rf_din", 32'(rf_din), 32'hBEEF);
      req = 3'b000;
      step();
      check("t2_w_done_we", 32'(rf_we), 0);
      check("t2_w_hold_addr", 32'(rf_addr), 3);
      set_req(0, 1'b0, 4'd3, 16'h0);
      req = 3'b001;
      step();
      check("t2_r_gnt", 32'(gnt), 32'b001);
      check("t2_r_rf_we", 32'(rf_we), 0);
      req = 3'b000;
      step();
      check("t2_r_rvalid", 32'(rvalid), 32'b001);
      check("t2_r_rdata", 32'(rdata), 32'hBEEF);
      step();

      // 3: ptr after lone req[2], then rotation 0,1,2,0
      set_req(2, 1'b0, 4'd0, 16'h0);
      req = 3'b100;
      step();
      check("t3_lone_gnt", 32'(gnt), 32'b100);
      req = 3'b000;
      step();
      check("t3_lone_rdata", 32'(rdata), 32'h1000);
      step();
      set_req(0, 1'b0, 4'd5, 16'h0);
      set_req(1, 1'b0, 4'd6, 16'h0);
      set_req(2, 1'b0, 4'd7, 16'h0);
      req = 3'b111;
      begin
         logic [2:0]  exp_g [4];
         logic [15:0] exp_d [4];
         exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
         exp_d = '{16'h1005, 16'h1006, 16'h1007, 16'h1005};
         for (int t = 0; t < 4; t++) begin
            step();
            check($sformatf("t3_gnt%0d", t), 32'(gnt), 32'(exp_g[t]));
            step();
            check($sformatf("t3_rvalid%0d", t), 32'(rvalid), 32'(exp_g[t]));
            check($sformatf("t3_rdata%0d", t), 32'(rdata), 32'(exp_d[t]));
            if (t == 3) req = 3'b000;
            step();
         end
      end

      // 4: unmapped address on requester 1 (ptr=1)
      set_req(1, 1'b0, 4'd4, 16'h0);
      req = 3'b010;
      step();
      check("t4_err", 32'(err), 32'b010);
      check("t4_no_gnt", 32'(gnt), 0);
      check("t4_rf_we", 32'(rf_we), 0);
      req = 3'b000;
      step();
      check("t4_no_rvalid", 32'(rvalid), 0);
      check("t4_err_clear", 32'(err), 0);
      set_req(1, 1'b0, 4'd6, 16'h0);
      req = 3'b111;
      step();
      check("t4_next_gnt", 32'(gnt), 32'b100);
      req = 3'b000;
      step();
      check("t4_next_rdata", 32'(rdata), 32'h1007);
      step();

      // 5: back-to-back read then write; late change of req_addr[0]
      set_req(0, 1'b0, 4'd3, 16'h0);
      set_req(1, 1'b1, 4'd9, 16'h1234);
      req = 3'b011;
      step();
      check("t5_gnt0", 32'(gnt), 32'b001);
      req = 3'b010;
      set_req(0, 1'b0, 4'd10, 16'h0);
      #1;
      check("t5_addr_stable", 32'(rf_addr), 3);
      step();
      check("t5_rvalid0", 32'(rvalid), 32'b001);
      check("t5_rdata0", 32'(rdata), 32'hBEEF);
      check("t5_addr_hold", 32'(rf_addr), 3);
      step();
      check("t5_idle_gnt", 32'(gnt), 0);
      step();
      check("t5_gnt1", 32'(gnt), 32'b010);
      check("t5_w_addr", 32'(rf_addr), 9);
      check("t5_w_din", 32'(rf_din), 32'h1234);
      check("t5_w_we", 32'(rf_we), 1);
      req = 3'b000;
      step();
      set_req(2, 1'b0, 4'd9, 16'h0);
      req = 3'b100;
      step();
      check("t5_rb_gnt", 32'(gnt), 32'b100);
      req = 3'b000;
      step();
      check("t5_rb_rdata", 32'(rdata), 32'h1234);
      step();

      // 6: req[0], req[2] always requesting, req[1] held
      set_req(0, 1'b0, 4'd0, 16'h0);
      set_req(1, 1'b0, 4'd2, 16'h0);
      set_req(2, 1'b0, 4'd1, 16'h0);
      req = 3'b111;
      others = 0;
      found = 1'b0;
      for (int c = 0; c < 30 && !found; c++) begin
         step();
         if (gnt != '0) begin
            if (gnt[1]) found = 1'b1;
            else others++;
         end
      end
      req = 3'b000;
      check("t6_found", 32'(found), 1);
      check("t6_others", 32'(others), 1);
      step();
      step();
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
